bram_port_arbiter: RTL and testbench
====================================

Name: bram_port_arbiter

Overview:
- Two-client round-robin arbiter sitting directly upstream of one block-RAM port (or a register write port).
- Muxes client requests onto a single memory request/response channel.
- Steers each memory response into a per-client one-entry response buffer.
- Requests and responses use the codebase's packed valid/bp channels; `bp` means backpressure, and a transfer occurs when `valid && ~bp`.

Parameters:
- `Width`, 8, data width of memory words.
- `AddrWidth`, 8, address width.
- `ReqWidth`, `Width+AddrWidth+1`, derived packed request width; do not override.

Ports:
- `clk` in 1: sole clock, rising edge.
- `resetn` in 1: reset, asynchronous, active-low.
- `c0_req` in ReqWidth: client 0 request; bit 0 = wr, `[Width:1]` = data, `[Width+AddrWidth:Width+1]` = addr.
- `c0_req_valid` in 1 / `c0_req_bp` out 1: client 0 request handshake.
- `c0_resp` out Width / `c0_resp_valid` out 1 / `c0_resp_bp` in 1: client 0 response channel.
- `c1_req`, `c1_req_valid`, `c1_req_bp`, `c1_resp`, `c1_resp_valid`, `c1_resp_bp`: same for client 1.
- `mem_req` out ReqWidth / `mem_req_valid` out 1 / `mem_req_bp` in 1: request to memory port.
- `mem_resp` in Width / `mem_resp_valid` in 1 / `mem_resp_bp` out 1: memory response. Memory returns it in the same cycle as the request; `mem_req_bp` may combinationally follow `mem_resp_bp`.

Behaviour:
- **Reset values.** All asserted asynchronously while `resetn`=0:
  - `c*_resp_valid`=0, `c*_resp`=0.
  - `prio`=0, `locked`=0, `lock_id`=0.
  - `mem_req_valid`=0, `c*_req_bp`=1.
- **Slot free.** `slot_free[i]` = `~c_i_resp_valid | ~c_i_resp_bp`, i.e. the slot is empty or draining this cycle.
- **Eligibility.** `elig[i]` = `c_i_req_valid & slot_free[i]`.
- **Grant (combinational).**
  - If `locked`: grant = `lock_id`.
  - Else if both clients are eligible: grant = `prio`.
  - Else grant = the single eligible client.
  - If neither is eligible: no grant.
- **Memory request.** `mem_req` = granted client's `c_req`. `mem_req_valid` = granted client's `req_valid` (0 if no grant).
- **Memory response backpressure.** `mem_resp_bp` = `~slot_free[grant]`.
- **Transfer.** `xfer` = `mem_req_valid & ~mem_req_bp`. `c_i_req_bp` = `~(xfer & grant==i)`.
- **Lock.**
  - On `mem_req_valid & mem_req_bp` with `~locked`: `locked`<=1, `lock_id`<=grant.
  - On `xfer`: `locked`<=0.
  - While locked, the grant and `mem_req` are stable; the other client waits even if eligible.
- **Round-robin.**
  - On `xfer` granted to i: `prio` <= `~i`.
  - With no transfer, `prio` is held.
- **Response buffer.**
  - On `xfer` to i: `c_i_resp` <= `mem_resp`, `c_i_resp_valid` <= 1.
  - Else if `c_i_resp_valid & ~c_i_resp_bp`: `c_i_resp_valid` <= 0.
  - Latency is 1 cycle from accepted request to response valid.
  - Writes also produce a response carrying `mem_resp` (pre-write data).
  - Throughput: 1 transfer per cycle across both clients; 1 per cycle per client while that client's response is consumed each cycle.
- **Simultaneous events.**
  - Capture and drain in the same cycle on one slot: capture wins, and valid stays 1.
  - The client dropping `req_valid` while locked is a protocol violation. No recovery is required, but the lock must clear on the next `xfer` or reset.
- **Reset mid-operation.**
  - Buffered responses are discarded and the lock is dropped.
  - Priority returns to client 0.

Optional Feature:
- Macro: `BRAM_PORT_ARBITER_STATS_EN`.
- **Defined.** Adds output ports `c0_grant_count` and `c1_grant_count`, 16 bits each.
  - Each increments on `xfer` to its client and saturates at 0xFFFF.
  - Reset value 0.
- **Undefined.** No such ports or counters exist; behaviour is otherwise identical.

Decomposition:
- **Package `bram_arb_pkg`.**
  - Request field offset constants: `WR_BIT`=0, `DATA_LSB`=1, `ADDR_LSB`=`Width+1`.
  - Client-id constants `CLIENT0`/`CLIENT1`.
  - Stats counter width constant (16).
- **Sub-module `bram_resp_slot`.**
  - One-entry response buffer with capture/drain/`slot_free` logic and reset.
  - Instantiated once per client.
  - The top holds the arbiter, lock and priority logic.

Test Plan (Width=8, AddrWidth=8):
1. **Reset.** Hold `resetn`=0 mid-traffic → `c0/c1_resp_valid`=0, `mem_req_valid`=0, `c0/c1_req_bp`=1 immediately (async), `prio`=0 after release.
2. **Single read.** c0 read addr 0x05, memory returns `mem_resp`=0xA5, no bp → `mem_req`=c0's request in the same cycle, `c0_req_bp`=0, next cycle `c0_resp`=0xA5 with `c0_resp_valid`=1.
3. **Fairness.** Both clients valid for 6 cycles, no bp → grant sequence c0,c1,c0,c1,c0,c1; each `resp_valid` pulses on alternate cycles.
4. **Lock.**
   - Stimulus: c0 granted with `mem_req_bp`=1 for 3 cycles while c1 is valid.
   - Required: `mem_req` stays c0's request for all 3 cycles; c0 transfers on the 4th; c1 is granted on the 5th.
5. **Response backpressure.**
   - Stimulus: c0 slot full with `c0_resp_bp`=1, c0 write addr 0x10 data 0x3C pending, c1 read pending.
   - Required: c1 served, c0 stalled (`c0_req_bp`=1); after `c0_resp_bp` drops, c0's write is transferred and `c0_resp` carries old data.
6. **Stats (`BRAM_PORT_ARBITER_STATS_EN`).** 70000 transfers to c0 → `c0_grant_count`=0xFFFF and holds; `c1_grant_count` unchanged.

Source files
------------

// File: rtl/bram_arb_pkg.sv
// Shared constants for the two-client block-RAM port arbiter: request field
// offsets, client identifiers and the width of the optional grant counters.
package bram_arb_pkg;

    localparam int WR_BIT        = 0;
    localparam int DATA_LSB      = 1;
    localparam int DEFAULT_WIDTH = 8;
    localparam int ADDR_LSB      = DEFAULT_WIDTH + 1;
    localparam int STATS_W       = 16;

    localparam logic CLIENT0 = 1'b0;
    localparam logic CLIENT1 = 1'b1;

    // Address field offset for a non-default data width.
    function automatic int addr_lsb(input int width);
        return width + 1;
    endfunction

endpackage

// File: rtl/bram_resp_slot.sv
// One-entry response buffer for a single arbiter client. A new capture always
// wins over a drain in the same cycle.
module bram_resp_slot #(
    parameter int Width = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             capture,
    input  logic [Width-1:0] capture_data,
    input  logic             resp_bp,
    output logic [Width-1:0] resp,
    output logic             resp_valid,
    output logic             slot_free
);

    logic [Width-1:0] data_reg;
    logic             valid_reg;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            data_reg  <= '0;
            valid_reg <= 1'b0;
        end else if (capture) begin
            data_reg  <= capture_data;
            valid_reg <= 1'b1;
        end else if (valid_reg && !resp_bp) begin
            valid_reg <= 1'b0;
        end
    end

    // Free when empty or being consumed this cycle, so back-to-back responses flow.
    assign slot_free  = ~valid_reg | ~resp_bp;
    assign resp       = data_reg;
    assign resp_valid = valid_reg;

endmodule

// File: rtl/bram_port_arbiter.sv
// Two-client round-robin arbiter in front of a single block-RAM port, with a
// per-client response slot. Define BRAM_PORT_ARBITER_STATS_EN for grant counters.
module bram_port_arbiter
    import bram_arb_pkg::*;
#(
    parameter int Width     = 8,
    parameter int AddrWidth = 8,
    parameter int ReqWidth  = Width + AddrWidth + 1
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [ReqWidth-1:0] c0_req,
    input  logic                c0_req_valid,
    output logic                c0_req_bp,
    output logic [Width-1:0]    c0_resp,
    output logic                c0_resp_valid,
    input  logic                c0_resp_bp,
    input  logic [ReqWidth-1:0] c1_req,
    input  logic                c1_req_valid,
    output logic                c1_req_bp,
    output logic [Width-1:0]    c1_resp,
    output logic                c1_resp_valid,
    input  logic                c1_resp_bp,
    output logic [ReqWidth-1:0] mem_req,
    output logic                mem_req_valid,
    input  logic                mem_req_bp,
    input  logic [Width-1:0]    mem_resp,
    input  logic                mem_resp_valid,
    output logic                mem_resp_bp
`ifdef BRAM_PORT_ARBITER_STATS_EN
    ,
    output logic [STATS_W-1:0]  c0_grant_count,
    output logic [STATS_W-1:0]  c1_grant_count
`endif
);

    logic [1:0]       req_valid;
    logic [1:0]       resp_bp;
    logic [1:0]       slot_free;
    logic [1:0]       resp_valid;
    logic [1:0]       elig;
    logic [1:0]       capture;
    logic [Width-1:0] resp_data [2];

    logic prio_reg;
    logic locked_reg;
    logic lock_id_reg;
    logic grant_any;
    logic grant_id;
    logic xfer;
    logic resp_valid_unused;

    assign req_valid = {c1_req_valid, c0_req_valid};
    assign resp_bp   = {c1_resp_bp, c0_resp_bp};
    assign elig      = req_valid & slot_free;

    // Responses arrive in the same cycle as the request, so mem_resp_valid adds nothing.
    assign resp_valid_unused = mem_resp_valid;

    always_comb begin
        grant_any = 1'b1;
        grant_id  = prio_reg;
        if (locked_reg) begin
            grant_id = lock_id_reg;
        end else if (elig == 2'b11) begin
            grant_id = prio_reg;
        end else if (elig[CLIENT0]) begin
            grant_id = CLIENT0;
        end else if (elig[CLIENT1]) begin
            grant_id = CLIENT1;
        end else begin
            grant_any = 1'b0;
        end
    end

    // Gating with resetn keeps the request side quiet while reset is held.
    assign mem_req_valid = resetn & grant_any & req_valid[grant_id];
    assign mem_req       = (grant_id == CLIENT1) ? c1_req : c0_req;
    assign mem_resp_bp   = ~slot_free[grant_id];
    assign xfer          = mem_req_valid & ~mem_req_bp;
    assign capture       = {xfer & (grant_id == CLIENT1), xfer & (grant_id == CLIENT0)};
    assign c0_req_bp     = ~capture[CLIENT0];
    assign c1_req_bp     = ~capture[CLIENT1];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            prio_reg    <= CLIENT0;
            locked_reg  <= 1'b0;
            lock_id_reg <= CLIENT0;
        end else if (xfer) begin
            prio_reg   <= ~grant_id;
            locked_reg <= 1'b0;
        end else if (mem_req_valid && !locked_reg) begin
            // Stalled by memory: freeze the grant until the request goes through.
            locked_reg  <= 1'b1;
            lock_id_reg <= grant_id;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_slot
            bram_resp_slot #(
                .Width(Width)
            ) u_slot (
                .clk          (clk),
                .resetn       (resetn),
                .capture      (capture[gi]),
                .capture_data (mem_resp),
                .resp_bp      (resp_bp[gi]),
                .resp         (resp_data[gi]),
                .resp_valid   (resp_valid[gi]),
                .slot_free    (slot_free[gi])
            );
        end
    endgenerate

    assign c0_resp       = resp_data[CLIENT0];
    assign c1_resp       = resp_data[CLIENT1];
    assign c0_resp_valid = resp_valid[CLIENT0];
    assign c1_resp_valid = resp_valid[CLIENT1];

`ifdef BRAM_PORT_ARBITER_STATS_EN
    logic [STATS_W-1:0] grant_count_reg [2];

    generate
        for (gi = 0; gi < 2; gi++) begin : g_stats
            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    grant_count_reg[gi] <= '0;
                end else if (capture[gi] && (grant_count_reg[gi] != '1)) begin
                    grant_count_reg[gi] <= grant_count_reg[gi] + 1'b1;
                end
            end
        end
    endgenerate

    assign c0_grant_count = grant_count_reg[CLIENT0];
    assign c1_grant_count = grant_count_reg[CLIENT1];
`endif

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed bench for bram_port_arbiter with a transaction-level reference model
// checked every cycle; stats checks run when BRAM_PORT_ARBITER_STATS_EN is defined.
module tb_bram_port_arbiter;

    localparam int W  = 8;
    localparam int AW = 8;
    localparam int RW = W + AW + 1;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic [RW-1:0] c0_req = '0;
    logic          c0_req_valid = 1'b0;
    logic          c0_resp_bp = 1'b0;
    logic [RW-1:0] c1_req = '0;
    logic          c1_req_valid = 1'b0;
    logic          c1_resp_bp = 1'b0;
    logic          force_bp = 1'b0;

    logic          c0_req_bp, c1_req_bp;
    logic [W-1:0]  c0_resp, c1_resp;
    logic          c0_resp_valid, c1_resp_valid;
    logic [RW-1:0] mem_req;
    logic          mem_req_valid;
    logic          mem_req_bp;
    logic [W-1:0]  mem_resp;
    logic          mem_resp_bp;
`ifdef BRAM_PORT_ARBITER_STATS_EN
    logic [15:0]   c0_grant_count, c1_grant_count;
`endif

    // Behavioural memory: combinational read, write on accepted request.
    logic [7:0] tb_mem [256];
    assign mem_resp   = tb_mem[mem_req[16:9]];
    assign mem_req_bp = force_bp | mem_resp_bp;

    always @(posedge clk) begin
        if (resetn && mem_req_valid && !mem_req_bp && mem_req[0])
            tb_mem[mem_req[16:9]] <= mem_req[8:1];
    end

    bram_port_arbiter #(.Width(W), .AddrWidth(AW)) dut (
        .clk            (clk),
        .resetn         (resetn),
        .c0_req         (c0_req),
        .c0_req_valid   (c0_req_valid),
        .c0_req_bp      (c0_req_bp),
        .c0_resp        (c0_resp),
        .c0_resp_valid  (c0_resp_valid),
        .c0_resp_bp     (c0_resp_bp),
        .c1_req         (c1_req),
        .c1_req_valid   (c1_req_valid),
        .c1_req_bp      (c1_req_bp),
        .c1_resp        (c1_resp),
        .c1_resp_valid  (c1_resp_valid),
        .c1_resp_bp     (c1_resp_bp),
        .mem_req        (mem_req),
        .mem_req_valid  (mem_req_valid),
        .mem_req_bp     (mem_req_bp),
        .mem_resp       (mem_resp),
        .mem_resp_valid (mem_req_valid),
        .mem_resp_bp    (mem_resp_bp)
`ifdef BRAM_PORT_ARBITER_STATS_EN
        ,
        .c0_grant_count (c0_grant_count),
        .c1_grant_count (c1_grant_count)
`endif
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [RW-1:0] mk(input logic wr, input logic [7:0] addr, input logic [7:0] data);
        return {addr, data, wr};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: who owns the port, whose turn it is, and what each client holds.
    logic [7:0]    m_mem [256];
    logic [1:0]    m_rv;
    logic [7:0]    m_rd [2];
    int            m_hold = -1;
    int            m_turn = 0;
    int            m_cnt [2];
    logic [RW-1:0] rq [2];
    logic [1:0]    rv, rb, fr, want;
    int            g;
    logic          ev, erb, ex;
    logic [7:0]    a;

    always @(negedge clk) begin
        rq[0] = c0_req;
        rq[1] = c1_req;
        rv    = {c1_req_valid, c0_req_valid};
        rb    = {c1_resp_bp, c0_resp_bp};
        if (!resetn) begin
            m_rv   = 2'b00;
            m_rd[0] = 8'h00;
            m_rd[1] = 8'h00;
            m_hold = -1;
            m_turn = 0;
            m_cnt[0] = 0;
            m_cnt[1] = 0;
            chk("rst_mem_req_valid", {31'd0, mem_req_valid}, 0);
            chk("rst_c0_req_bp", {31'd0, c0_req_bp}, 1);
            chk("rst_c1_req_bp", {31'd0, c1_req_bp}, 1);
            chk("rst_c0_resp_valid", {31'd0, c0_resp_valid}, 0);
            chk("rst_c1_resp_valid", {31'd0, c1_resp_valid}, 0);
            chk("rst_c0_resp", {24'd0, c0_resp}, 0);
            chk("rst_c1_resp", {24'd0, c1_resp}, 0);
        end else begin
            for (int i = 0; i < 2; i++) begin
                fr[i]   = !m_rv[i] || !rb[i];
                want[i] = rv[i] && fr[i];
            end
            if (m_hold >= 0)        g = m_hold;
            else if (want == 2'b11) g = m_turn;
            else if (want[0])       g = 0;
            else if (want[1])       g = 1;
            else                    g = -1;
            ev  = (g >= 0) && rv[g];
            erb = (g >= 0) && !fr[g];
            ex  = ev && !(force_bp || erb);

            chk("mem_req_valid", {31'd0, mem_req_valid}, {31'd0, ev});
            if (ev) chk("mem_req", {15'd0, mem_req}, {15'd0, rq[g]});
            if (g >= 0) chk("mem_resp_bp", {31'd0, mem_resp_bp}, {31'd0, erb});
            chk("c0_req_bp", {31'd0, c0_req_bp}, {31'd0, !(ex && g == 0)});
            chk("c1_req_bp", {31'd0, c1_req_bp}, {31'd0, !(ex && g == 1)});
            chk("c0_resp_valid", {31'd0, c0_resp_valid}, {31'd0, m_rv[0]});
            chk("c1_resp_valid", {31'd0, c1_resp_valid}, {31'd0, m_rv[1]});
            if (m_rv[0]) chk("c0_resp", {24'd0, c0_resp}, {24'd0, m_rd[0]});
            if (m_rv[1]) chk("c1_resp", {24'd0, c1_resp}, {24'd0, m_rd[1]});

            for (int i = 0; i < 2; i++)
                if (m_rv[i] && !rb[i]) m_rv[i] = 1'b0;
            if (ex) begin
                a       = rq[g][16:9];
                m_rd[g] = m_mem[a];
                m_rv[g] = 1'b1;
                if (rq[g][0]) m_mem[a] = rq[g][8:1];
                m_hold   = -1;
                m_turn   = 1 - g;
                m_cnt[g] = m_cnt[g] + 1;
            end else if (ev && m_hold < 0) begin
                m_hold = g;
            end
        end
    end

    int gid;

    initial begin
        for (int i = 0; i < 256; i++) begin
            tb_mem[i] = 8'(i) ^ 8'hA0;
            m_mem[i]  = 8'(i) ^ 8'hA0;
        end
        m_cnt[0] = 0;
        m_cnt[1] = 0;
        resetn = 1'b0;
        repeat (2) tick();
        #1;
        chk("t1_hold_c0_req_bp", {31'd0, c0_req_bp}, 1);
        chk("t1_hold_mem_req_valid", {31'd0, mem_req_valid}, 0);
        resetn = 1'b1;

        // Single read from client 0.
        tick();
        c0_req = mk(1'b0, 8'h05, 8'h00);
        c0_req_valid = 1'b1;
        #1;
        chk("t2_mem_req", {15'd0, mem_req}, {15'd0, mk(1'b0, 8'h05, 8'h00)});
        chk("t2_c0_req_bp", {31'd0, c0_req_bp}, 0);
        tick();
        c0_req_valid = 1'b0;
        c1_req = mk(1'b0, 8'h20, 8'h00);
        c1_req_valid = 1'b1;
        #1;
        chk("t2_c0_resp", {24'd0, c0_resp}, 32'hA5);
        chk("t2_c0_resp_valid", {31'd0, c0_resp_valid}, 1);
        $display("t2 single read: c0_resp=%0h", c0_resp);

        // Asynchronous reset in the middle of traffic.
        resetn = 1'b0;
        #1;
        chk("t1_async_c0_resp_valid", {31'd0, c0_resp_valid}, 0);
        chk("t1_async_c0_resp", {24'd0, c0_resp}, 0);
        chk("t1_async_mem_req_valid", {31'd0, mem_req_valid}, 0);
        chk("t1_async_c1_req_bp", {31'd0, c1_req_bp}, 1);
        tick();
        resetn = 1'b1;
        c0_req = mk(1'b0, 8'h07, 8'h00);
        c0_req_valid = 1'b1;
        #1;
        chk("t1_prio_after_reset", {15'd0, mem_req}, {15'd0, mk(1'b0, 8'h07, 8'h00)});
        chk("t1_c1_waits", {31'd0, c1_req_bp}, 1);
        $display("t1 reset: mem_req=%0h after release", mem_req);
        tick();
        c0_req_valid = 1'b0;
        tick();
        c1_req_valid = 1'b0;
        tick();

        // Fairness: both clients continuously requesting.
        for (int k = 0; k < 6; k++) begin
            tick();
            if (k == 0) begin
                c0_req = mk(1'b0, 8'h30, 8'h00);
                c1_req = mk(1'b0, 8'h31, 8'h00);
                c0_req_valid = 1'b1;
                c1_req_valid = 1'b1;
            end
            #1;
            gid = !c0_req_bp ? 0 : (!c1_req_bp ? 1 : 3);
            chk("t3_grant", gid, k % 2);
            if (k > 0) begin
                chk("t3_prev_resp_valid", {31'd0, ((k - 1) % 2 == 0) ? c0_resp_valid : c1_resp_valid}, 1);
                chk("t3_other_resp_valid", {31'd0, (k % 2 == 0) ? c0_resp_valid : c1_resp_valid}, 0);
            end
            $display("t3 cycle %0d: grant=c%0d", k, gid);
        end
        tick();
        c0_req_valid = 1'b0;
        c1_req_valid = 1'b0;
        #1;
        chk("t3_last_c1_resp", {24'd0, c1_resp}, 32'h91);
        tick();

        // Lock: c0 stalled by the memory while c1 would otherwise win.
        tick();
        c0_req = mk(1'b0, 8'h40, 8'h00);
        c0_req_valid = 1'b1;
        #1;
        chk("t4_pre_xfer", {31'd0, c0_req_bp}, 0);
        tick();
        force_bp = 1'b1;
        #1;
        chk("t4_lock_req", {15'd0, mem_req}, {15'd0, mk(1'b0, 8'h40, 8'h00)});
        chk("t4_lock_c0_bp", {31'd0, c0_req_bp}, 1);
        for (int j = 0; j < 2; j++) begin
            tick();
            c1_req = mk(1'b0, 8'h41, 8'h00);
            c1_req_valid = 1'b1;
            #1;
            chk("t4_hold_req", {15'd0, mem_req}, {15'd0, mk(1'b0, 8'h40, 8'h00)});
            chk("t4_hold_c1_bp", {31'd0, c1_req_bp}, 1);
            $display("t4 locked cycle %0d: mem_req=%0h", j, mem_req);
        end
        tick();
        force_bp = 1'b0;
        #1;
        chk("t4_release_c0", {31'd0, c0_req_bp}, 0);
        chk("t4_release_c1", {31'd0, c1_req_bp}, 1);
        tick();
        c0_req_valid = 1'b0;
        #1;
        chk("t4_c1_next", {31'd0, c1_req_bp}, 0);
        chk("t4_c0_resp", {24'd0, c0_resp}, 32'hE0);
        tick();
        c1_req_valid = 1'b0;
        #1;
        chk("t4_c1_resp", {24'd0, c1_resp}, 32'hE1);
        tick();

        // Response backpressure on client 0.
        tick();
        c0_req = mk(1'b0, 8'h50, 8'h00);
        c0_req_valid = 1'b1;
        c0_resp_bp = 1'b1;
        #1;
        chk("t5_fill", {31'd0, c0_req_bp}, 0);
        tick();
        c0_req = mk(1'b1, 8'h10, 8'h3C);
        c1_req = mk(1'b0, 8'h51, 8'h00);
        c1_req_valid = 1'b1;
        #1;
        chk("t5_c1_served", {31'd0, c1_req_bp}, 0);
        chk("t5_c0_stall", {31'd0, c0_req_bp}, 1);
        chk("t5_c0_held", {24'd0, c0_resp}, 32'hF0);
        tick();
        c1_req_valid = 1'b0;
        #1;
        chk("t5_c0_stall2", {31'd0, c0_req_bp}, 1);
        chk("t5_idle", {31'd0, mem_req_valid}, 0);
        chk("t5_c1_resp", {24'd0, c1_resp}, 32'hF1);
        tick();
        c0_resp_bp = 1'b0;
        #1;
        chk("t5_c0_go", {31'd0, c0_req_bp}, 0);
        chk("t5_write_req", {15'd0, mem_req}, {15'd0, mk(1'b1, 8'h10, 8'h3C)});
        tick();
        c0_req = mk(1'b0, 8'h10, 8'h00);
        #1;
        chk("t5_old_data", {24'd0, c0_resp}, 32'hB0);
        tick();
        c0_req_valid = 1'b0;
        #1;
        chk("t5_new_data", {24'd0, c0_resp}, 32'h3C);
        $display("t5 backpressure: write 0x10 returned old, readback=%0h", c0_resp);
        tick();
        tick();

`ifdef BRAM_PORT_ARBITER_STATS_EN
        chk("t6_c1_before", {16'd0, c1_grant_count}, m_cnt[1]);
        tick();
        c0_req = mk(1'b0, 8'h01, 8'h00);
        c0_req_valid = 1'b1;
        repeat (70000) tick();
        c0_req_valid = 1'b0;
        #1;
        chk("t6_c0_sat", {16'd0, c0_grant_count}, 32'hFFFF);
        chk("t6_c1_unchanged", {16'd0, c1_grant_count}, m_cnt[1]);
        tick();
        tick();
        chk("t6_c0_holds", {16'd0, c0_grant_count}, 32'hFFFF);
        $display("t6 stats: c0=%0h c1=%0h", c0_grant_count, c1_grant_count);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
